if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues req/ack fetches to instruction memory, drives if_pc/if_inst into if_id.
//  Absorbs variable memory latency, pipeline stalls and branch/flush redirects.
//  Raises stallreq_if to ctrl while no valid instruction is available.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  PC_STEP    4              byte increment per sequential fetch
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous reset, active-low (`RstEnable = 1'b0)
//  stall          in   1   from ctrl; `StallNo = if_id accepts this cycle
//  branch_flag    in   1   taken branch/jump resolved in ID
//  branch_target  in   32  branch destination PC
//  flush          in   1   exception/eret redirect, overrides all
//  new_pc         in   32  flush destination PC
//  inst_req       out  1   fetch request to instruction memory
//  inst_addr      out  32  fetch address; stable while inst_req=1 and no ack
//  inst_ack       in   1   memory completes the fetch this cycle (may be the first req cycle)
//  inst_rdata     in   32  instruction word, valid only when inst_ack=1
//  if_pc          out  32  PC of the instruction presented to if_id
//  if_inst        out  32  instruction presented to if_id; `ZeroInst (bubble) when none is valid
//  stallreq_if    out  1   1 = no valid instruction this cycle, ctrl must stall
// BEHAVIOUR
//  Reset (rst==1'b0 at posedge): pc=RESET_PC, state=FETCH next, buffer cleared.
//   While rst low: inst_req=0, if_pc=RESET_PC, if_inst=0, stallreq_if=0.
//  States: FETCH, HOLD, DISCARD.
//  FETCH: inst_req=1, inst_addr=pc, if_pc=pc.
//   ack & no redirect & stall==StallNo: if_inst=inst_rdata (same cycle), stallreq_if=0; pc<=pc+PC_STEP; stay FETCH.
//   ack & stall!=StallNo: capture inst_rdata in buffer; -> HOLD.
//   no ack: if_inst=0, stallreq_if=1; address held.
//  HOLD: inst_req=0, if_inst=buffer, if_pc=pc, stallreq_if=0.
//   stall==StallNo: pc<=pc+PC_STEP; -> FETCH.
//  DISCARD: inst_req=1, inst_addr=old pc (request already issued must complete); if_inst=0, stallreq_if=1.
//   on ack: drop data, pc<=saved redirect target; -> FETCH.
//  Redirects:
//   - Priority: flush > branch_flag.
//   - flush is honoured even when stalled. branch_flag is honoured only when stall==StallNo.
//   - Target goes to pc. If a request is outstanding with no ack, the target goes to a redirect register and the state goes to DISCARD.
//   - Redirect in the same cycle as ack: data dropped, pc<=target, FETCH.
//   - Redirect in HOLD: buffer dropped, pc<=target, FETCH.
//   - Redirect in DISCARD: the newer redirect overwrites the saved target.
//  Outputs depend combinationally on inst_ack/inst_rdata; the zero-wait memory path must give 1 instruction per cycle.
//  PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
//  Reset mid-fetch: request abandoned (inst_req drops); memory must tolerate this.
// STRUCTURE
//  defines.v:
//   - existing: `RstEnable, `StallNo, `ZeroInst, `InstAddrBus, `InstBus.
//   - add: `IfStFetch/`IfStHold/`IfStDiscard (2-bit encodings).
//  Single module, no sub-module. Holding buffer and redirect register stay inline (one 32-bit reg each).
// TESTING
//  1. Zero-wait memory (ack=req), stall=StallNo, 4 cycles after reset
//     -> if_pc 0,4,8,C on consecutive cycles; stallreq_if=0 throughout.
//  2. Memory 2 wait states at pc=0x10
//     -> stallreq_if=1, if_inst=0 for 2 cycles, inst_addr=0x10 held; 3rd cycle if_inst=rdata, pc->0x14.
//  3. Ack at pc=0x20 while stall=1 for 3 cycles
//     -> HOLD, inst_req=0, if_inst=buffer, pc stays 0x20; first unstalled cycle pc->0x24.
//  4. branch_flag, target 0x100, during pending fetch of 0x40
//     -> DISCARD; inst_addr stays 0x40 until ack; data dropped; next req addr=0x100.
//  5. flush(new_pc=0x180) and branch_flag(0x200) in the same cycle, stall=1
//     -> next fetch address 0x180.
//  6. pc=32'hFFFF_FFFC, ack -> next inst_addr=0. rst low mid-wait -> inst_req=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the fetch stage.
// Imported by the fetch interface, the stage and its bench.
package if_fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam logic  RST_ENABLE = 1'b0;
  localparam logic  STALL_NO   = 1'b0;
  localparam inst_t ZERO_INST  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } if_state_e;

  function automatic addr_t pc_add(
    input addr_t pc,
    input addr_t step
  );
    return pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: req/ack instruction-memory bus.
// master = fetch stage, slave = instruction memory.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic  inst_req;
  addr_t inst_addr;
  logic  inst_ack;
  inst_t inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ack,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ack,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC.
// Absorbs memory latency, pipeline stalls and redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter addr_t PC_STEP  = 32'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_flag,
  input  addr_t      branch_target,
  input  logic       flush,
  input  addr_t      new_pc,
  if_fetch_if.master mem,
  output addr_t      if_pc,
  output inst_t      if_inst,
  output logic       stallreq_if
);

  if_state_e state_q, state_d;
  addr_t     pc_q, pc_d;
  addr_t     redir_q, redir_d;
  inst_t     buf_q, buf_d;

  logic  go;
  logic  redir;
  addr_t target;
  logic  req;
  inst_t inst;
  logic  sreq;

  assign go     = (stall == STALL_NO);
  assign redir  = flush | (branch_flag & go);
  assign target = flush ? new_pc : branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    buf_d   = buf_q;
    req     = 1'b0;
    inst    = ZERO_INST;
    sreq    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        req  = 1'b1;
        // stallreq_if never looks at stall: ctrl derives stall from it
        sreq = ~mem.inst_ack;
        if (redir) begin
          if (mem.inst_ack) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = ST_DISCARD;
          end
        end else if (mem.inst_ack) begin
          inst = mem.inst_rdata;
          if (go) begin
            pc_d = pc_add(pc_q, PC_STEP);
          end else begin
            buf_d   = mem.inst_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else begin
          inst = buf_q;
          if (go) begin
            pc_d    = pc_add(pc_q, PC_STEP);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DISCARD: begin
        req  = 1'b1;
        sreq = 1'b1;
        if (redir) redir_d = target;
        if (mem.inst_ack) begin
          pc_d    = redir ? target : redir_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (rst == RST_ENABLE) begin
      req  = 1'b0;
      inst = ZERO_INST;
      sreq = 1'b0;
    end
  end

  assign mem.inst_req  = req;
  assign mem.inst_addr = pc_q;
  assign if_inst       = inst;
  assign stallreq_if   = sreq;
  assign if_pc = (rst == RST_ENABLE) ? RESET_PC : pc_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      buf_q   <= ZERO_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios, then random traffic
// scored against a program-order PC model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam addr_t RPC  = 32'h0000_0000;
  localparam inst_t JUNK = 32'hDEAD_0000;

  typedef struct {
    addr_t pc;
    inst_t inst;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  stall;
  logic  branch_flag;
  addr_t branch_target;
  logic  flush;
  addr_t new_pc;
  addr_t if_pc;
  inst_t if_inst;
  logic  stallreq_if;

  if_fetch_if mem_if();

  if_fetch #(.RESET_PC(RPC), .PC_STEP(32'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .mem           (mem_if),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;
  logic sb_on = 1'b0;
  exp_t q[$];

  function automatic inst_t word_at(input addr_t a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic mem_set(input logic a, input addr_t pc);
    mem_if.inst_ack   = a;
    mem_if.inst_rdata = a ? word_at(pc) : JUNK;
  endtask

  // Expected program-order stream from a given PC.
  task automatic push_seq(input addr_t start);
    addr_t p;
    exp_t  e;
    q.delete();
    p = start;
    for (int i = 0; i < 256; i++) begin
      e.pc   = p;
      e.inst = word_at(p);
      q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // Monitor: protocol checks and in-order delivery scoring.
  logic  prev_wait = 1'b0;
  addr_t prev_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (sb_on) begin
      if (!rst) begin
        chk("rst_outs",
            {mem_if.inst_req, stallreq_if, if_inst, if_pc},
            {1'b0, 1'b0, ZERO_INST, RPC});
        prev_wait = 1'b0;
      end else begin
        if (prev_wait)
          chk("addr_hold", {mem_if.inst_req, mem_if.inst_addr},
              {1'b1, prev_addr});
        if (stallreq_if)
          chk("bubble_on_stallreq", if_inst, ZERO_INST);
        if (!stall && !stallreq_if && if_inst != ZERO_INST) begin
          delivered++;
          if (q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = q.pop_front();
            chk("sb_pc", if_pc, e.pc);
            chk("sb_inst", if_inst, e.inst);
          end
        end
        prev_wait = mem_if.inst_req & ~mem_if.inst_ack;
        prev_addr = mem_if.inst_addr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic  busy;
    int    lat;
    int    since;
    addr_t tgt;
    logic  rd;

    rst = 1'b0; stall = 1'b0;
    branch_flag = 1'b0; branch_target = '0;
    flush = 1'b0; new_pc = '0;
    mem_set(1'b0, '0);

    // reset state
    tick();
    settle();
    chk("rst_req", mem_if.inst_req, 0);
    chk("rst_pc", if_pc, RPC);
    chk("rst_inst", if_inst, ZERO_INST);
    chk("rst_sreq", stallreq_if, 0);
    rst = 1'b1;

    // zero-wait: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      mem_set(1'b1, 32'(i * 4));
      settle();
      chk("zw_pc", if_pc, 32'(i * 4));
      chk("zw_inst", if_inst, word_at(32'(i * 4)));
      chk("zw_sreq", stallreq_if, 0);
      tick();
    end

    // two wait states at 0x10
    for (int k = 0; k < 2; k++) begin
      mem_set(1'b0, '0);
      settle();
      chk("ws_sreq", stallreq_if, 1);
      chk("ws_inst", if_inst, ZERO_INST);
      chk("ws_addr", mem_if.inst_addr, 32'h10);
      tick();
    end
    mem_set(1'b1, 32'h10);
    settle();
    chk("ws_data", if_inst, word_at(32'h10));
    tick();
    for (int a = 32'h14; a < 32'h20; a += 4) begin
      mem_set(1'b1, 32'(a));
      settle();
      chk("seq_pc", if_pc, 32'(a));
      tick();
    end

    // ack at 0x20 under stall -> hold buffer
    stall = 1'b1;
    mem_set(1'b1, 32'h20);
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_set(1'b0, '0);
      settle();
      chk("hold_req", mem_if.inst_req, 0);
      chk("hold_inst", if_inst, word_at(32'h20));
      chk("hold_pc", if_pc, 32'h20);
      chk("hold_sreq", stallreq_if, 0);
      tick();
    end
    stall = 1'b0;
    settle();
    chk("hold_release", if_inst, word_at(32'h20));
    tick();
    settle();
    chk("hold_next", mem_if.inst_addr, 32'h24);
    for (int a = 32'h24; a < 32'h40; a += 4) begin
      mem_set(1'b1, 32'(a));
      settle();
      tick();
    end

    // branch while 0x40 is pending -> discard
    mem_set(1'b0, '0);
    branch_flag = 1'b1; branch_target = 32'h100;
    settle();
    chk("br_bubble", if_inst, ZERO_INST);
    tick();
    branch_flag = 1'b0;
    settle();
    chk("disc_addr", mem_if.inst_addr, 32'h40);
    chk("disc_req", mem_if.inst_req, 1);
    chk("disc_sreq", stallreq_if, 1);
    tick();
    mem_set(1'b1, 32'h40);
    settle();
    chk("disc_drop", if_inst, ZERO_INST);
    tick();
    mem_set(1'b0, '0);
    settle();
    chk("br_target", mem_if.inst_addr, 32'h100);

    // flush beats branch, honoured under stall
    flush = 1'b1; new_pc = 32'h180;
    branch_flag = 1'b1; branch_target = 32'h200;
    stall = 1'b1;
    tick();
    flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
    mem_set(1'b1, 32'h100);
    settle();
    chk("fl_drop", if_inst, ZERO_INST);
    tick();
    settle();
    chk("fl_prio", mem_if.inst_addr, 32'h180);

    // flush with ack: data dropped, wrap at top of memory
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    mem_set(1'b1, 32'h180);
    settle();
    chk("fl_ack_drop", if_inst, ZERO_INST);
    tick();
    flush = 1'b0;
    mem_set(1'b1, 32'hFFFF_FFFC);
    settle();
    chk("top_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    settle();
    chk("wrap", mem_if.inst_addr, 32'h0);
    tick();
    mem_set(1'b0, '0);
    settle();
    chk("wait4", mem_if.inst_addr, 32'h4);
    tick();
    rst = 1'b0;
    settle();
    chk("midrst_req", mem_if.inst_req, 0);
    tick();
    rst = 1'b1;
    settle();
    chk("midrst_pc", mem_if.inst_addr, RPC);
    chk("midrst_req1", mem_if.inst_req, 1);

    // random traffic scored against the program-order model
    busy = 1'b0; lat = 0; since = 0;
    sb_on = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      #1;
      rst = !(it == 0 || $urandom_range(0, 299) == 0);
      flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
      if (!rst) begin
        push_seq(RPC);
        since = 0;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 29) == 0) || (since >= 200);
        branch_flag = ($urandom_range(0, 11) == 0);
        new_pc = $urandom & 32'hFFFF_FFFC;
        branch_target = ($urandom_range(0, 7) == 0) ?
          32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        rd = flush || (branch_flag && !stall);
        tgt = flush ? new_pc : branch_target;
        if (rd) begin
          push_seq(tgt);
          since = 0;
        end else begin
          since++;
        end
      end
      #1;
      if (mem_if.inst_req) begin
        if (!busy) begin
          busy = 1'b1;
          lat = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
        if (lat == 0) begin
          mem_set(1'b1, mem_if.inst_addr);
          busy = 1'b0;
        end else begin
          mem_set(1'b0, '0);
          lat--;
        end
      end else begin
        mem_set(1'b0, '0);
        busy = 1'b0;
      end
    end
    @(negedge clk);
    sb_on = 1'b0;
    chk("min_deliveries", 32'(delivered >= 300), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
